johnson_decoder: RTL and testbench

//  Receive-side companion of the Johnson counter generator. Samples a Johnson-coded word,

---
 rtl/johnson_decoder.sv | 142 ++++++++++++++
 tb/tb_johnson_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: checks legality, decodes to a step index and tracks sequence lock.
// Latency 2 enabled edges, 1 sample/cycle, no backpressure; ena=0 freezes every register.
module johnson_decoder #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [WIDTH-1:0]              code_in,
    input  logic                          code_valid,
    output logic [$clog2(2*WIDTH)-1:0]    count_out,
    output logic                          valid_out,
    output logic                          locked,
    output logic                          err_illegal,
    output logic                          err_seq,
    output logic [7:0]                    err_count
);

    localparam int CW = $clog2(2*WIDTH);
    localparam int GW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  s1_code;
    logic              s1_vld;
    logic [CW-1:0]     prev;
    logic [GW-1:0]     good_cnt;

    logic [CW-1:0]     dec_idx;
    logic [CW-1:0]     succ_idx;
    logic              legal;
    logic              is_succ;
    logic              is_rep;
    logic              seq_break;
    logic              bump_err;

    function automatic logic [CW-1:0] decode_code(input logic [WIDTH-1:0] c);
        int pc;
        pc = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pc += int'(c[i]);
        end
        if (c == '0) begin
            return '0;
        end
        if (c[0]) begin
            return CW'(pc);
        end
        return CW'(2*WIDTH - pc);
    endfunction

    function automatic logic [WIDTH-1:0] encode_idx(input logic [CW-1:0] k);
        logic [WIDTH-1:0] e;
        int ki;
        ki = int'(k);
        for (int i = 0; i < WIDTH; i++) begin
            e[i] = (ki <= WIDTH) ? (i < ki) : (i >= ki - WIDTH);
        end
        return e;
    endfunction

    // A word is legal exactly when re-encoding its decoded index reproduces it.
    assign dec_idx   = decode_code(s1_code);
    assign legal     = (encode_idx(dec_idx) == s1_code);
    assign succ_idx  = (prev == CW'(2*WIDTH - 1)) ? '0 : prev + CW'(1);
    assign is_succ   = (dec_idx == succ_idx);
    assign is_rep    = (dec_idx == prev);
    assign seq_break = legal && (state == LOCKED) && !is_succ && !is_rep;
    assign bump_err  = s1_vld && (!legal || seq_break);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_code     <= '0;
            s1_vld      <= 1'b0;
            state       <= UNLOCKED;
            prev        <= '0;
            good_cnt    <= '0;
            count_out   <= '0;
            valid_out   <= 1'b0;
            locked      <= 1'b0;
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_count   <= '0;
        end else if (ena) begin
            s1_code     <= code_in;
            s1_vld      <= code_valid;
            valid_out   <= s1_vld;
            err_illegal <= s1_vld && !legal;
            err_seq     <= s1_vld && seq_break;

            if (bump_err && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end

            if (s1_vld) begin
                if (!legal) begin
                    state    <= UNLOCKED;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end else begin
                    count_out <= dec_idx;
                    prev      <= dec_idx;
                    unique case (state)
                        UNLOCKED: begin
                            state    <= LOCKING;
                            good_cnt <= GW'(1);
                        end
                        LOCKING: begin
                            if (is_succ) begin
                                good_cnt <= good_cnt + GW'(1);
                                if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else if (!is_rep) begin
                                good_cnt <= GW'(1);
                            end
                        end
                        LOCKED: begin
                            if (!is_succ && !is_rep) begin
                                state    <= LOCKING;
                                locked   <= 1'b0;
                                good_cnt <= GW'(1);
                            end
                        end
                        default: begin
                            state  <= UNLOCKED;
                            locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: directed Johnson vectors with hand-computed results.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] code_in;
    logic       code_valid;
    logic [3:0] count_out;
    logic       valid_out;
    logic       locked;
    logic       err_illegal;
    logic       err_seq;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       lk;
        logic       ill;
        logic       sq;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];

    johnson_decoder #(.WIDTH(8), .LOCK_COUNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .count_out   (count_out),
        .valid_out   (valid_out),
        .locked      (locked),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [3:0] cnt, input logic lk,
                        input logic ill, input logic sq, input logic [7:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        ena        = 1'b1;
        code_valid = 1'b1;
        code_in    = c;
        e.cnt = cnt; e.lk = lk; e.ill = ill; e.sq = sq; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ena        = 1'b1;
            code_valid = 1'b0;
        end
    endtask

    // Monitor: compares only on edges where ena was high, since pulses persist while frozen.
    initial begin
        logic en_edge;
        exp_t e;
        forever begin
            @(posedge clk);
            en_edge = ena;
            @(negedge clk);
            if (en_edge && valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_out", 32'(valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("count_out",   32'(count_out),   32'(e.cnt));
                    chk("locked",      32'(locked),      32'(e.lk));
                    chk("err_illegal", 32'(err_illegal), 32'(e.ill));
                    chk("err_seq",     32'(err_seq),     32'(e.sq));
                    chk("err_count",   32'(err_count),   32'(e.ec));
                end
            end else if (en_edge) begin
                chk("stray_err_pulse", 32'({err_illegal, err_seq}), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; ena = 1'b0; code_in = 8'h00; code_valid = 1'b0;
        #3;
        chk("rst_count_out", 32'(count_out), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_locked",    32'(locked),    32'd0);
        chk("rst_errs",      32'({err_illegal, err_seq}), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lock-up followed by a full lap through the wrap point
        send(8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'd0);
        send(8'h01, 4'd1,  1'b0, 1'b0, 1'b0, 8'd0);
        send(8'h03, 4'd2,  1'b0, 1'b0, 1'b0, 8'd0);
        send(8'h07, 4'd3,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h0F, 4'd4,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h1F, 4'd5,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h3F, 4'd6,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h7F, 4'd7,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'hFF, 4'd8,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'hFE, 4'd9,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'hFC, 4'd10, 1'b1, 1'b0, 1'b0, 8'd0);
        send(8'hF8, 4'd11, 1'b1, 1'b0, 1'b0, 8'd0);
        send(8'hF0, 4'd12, 1'b1, 1'b0, 1'b0, 8'd0);
        send(8'hE0, 4'd13, 1'b1, 1'b0, 1'b0, 8'd0);
        send(8'hC0, 4'd14, 1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h80, 4'd15, 1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h00, 4'd0,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h01, 4'd1,  1'b1, 1'b0, 1'b0, 8'd0);
        send(8'h03, 4'd2,  1'b1, 1'b0, 1'b0, 8'd0);
        // Illegal word while locked
        send(8'h05, 4'd2,  1'b0, 1'b1, 1'b0, 8'd1);
        // Relock across the wrap, then a skip
        send(8'hC0, 4'd14, 1'b0, 1'b0, 1'b0, 8'd1);
        send(8'h80, 4'd15, 1'b0, 1'b0, 1'b0, 8'd1);
        send(8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'd1);
        send(8'h01, 4'd1,  1'b1, 1'b0, 1'b0, 8'd1);
        send(8'h03, 4'd2,  1'b1, 1'b0, 1'b0, 8'd1);
        send(8'h0F, 4'd4,  1'b0, 1'b0, 1'b1, 8'd2);
        send(8'h1F, 4'd5,  1'b0, 1'b0, 1'b0, 8'd2);
        send(8'h3F, 4'd6,  1'b0, 1'b0, 1'b0, 8'd2);
        send(8'h7F, 4'd7,  1'b1, 1'b0, 1'b0, 8'd2);
        send(8'h7F, 4'd7,  1'b1, 1'b0, 1'b0, 8'd2);
        // Backward jump, repeat while locking, and a jump while locking
        send(8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 8'd3);
        send(8'h01, 4'd1,  1'b0, 1'b0, 1'b0, 8'd3);
        send(8'h01, 4'd1,  1'b0, 1'b0, 1'b0, 8'd3);
        send(8'h03, 4'd2,  1'b0, 1'b0, 1'b0, 8'd3);
        send(8'hFF, 4'd8,  1'b0, 1'b0, 1'b0, 8'd3);
        send(8'hFE, 4'd9,  1'b0, 1'b0, 1'b0, 8'd3);
        send(8'hFC, 4'd10, 1'b0, 1'b0, 1'b0, 8'd3);
        send(8'hF8, 4'd11, 1'b1, 1'b0, 1'b0, 8'd3);
        idle(3);
        send(8'hF0, 4'd12, 1'b1, 1'b0, 1'b0, 8'd3);
        send(8'hE0, 4'd13, 1'b1, 1'b0, 1'b0, 8'd3);

        // Freeze with traffic: the 0xF0 result and its valid pulse must stay put
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            ena        = 1'b0;
            code_valid = 1'b1;
            code_in    = 8'h05;
            @(negedge clk);
            chk("hold_count_out", 32'(count_out), 32'd12);
            chk("hold_locked",    32'(locked),    32'd1);
            chk("hold_valid_out", 32'(valid_out), 32'd1);
            chk("hold_err_count", 32'(err_count), 32'd3);
            chk("hold_err_ill",   32'(err_illegal), 32'd0);
        end
        @(posedge clk);
        #1;
        ena        = 1'b1;
        code_valid = 1'b0;

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send(8'h05, 4'd13, 1'b0, 1'b1, 1'b0, (4 + i > 255) ? 8'd255 : 8'(4 + i));
        end
        send(8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 8'd255);
        send(8'h01, 4'd1,  1'b0, 1'b0, 1'b0, 8'd255);
        send(8'h03, 4'd2,  1'b0, 1'b0, 1'b0, 8'd255);
        send(8'h07, 4'd3,  1'b1, 1'b0, 1'b0, 8'd255);
        send(8'h0F, 4'd4,  1'b1, 1'b0, 1'b0, 8'd255);

        // Reset with 0x0F in flight: it must be dropped
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_locked", 32'(locked), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t1_count_out", 32'(count_out), 32'd0);
        chk("t1_valid_out", 32'(valid_out), 32'd0);
        chk("t1_locked",    32'(locked),    32'd0);
        chk("t1_errs",      32'({err_illegal, err_seq}), 32'd0);
        chk("t1_err_count", 32'(err_count), 32'd0);
        code_in = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        code_valid = 1'b0;
        idle(3);
        send(8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        idle(1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
